// File: rtl/arr_arbiter.sv
// Two-kernel round-robin arbiter with grant locking in front of a single-port array.
// The host has absolute priority and is passed straight through to the array port.
module arr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_sel,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              k0_req,
  input  logic              k0_we,
  input  logic              k0_lock,
  input  logic [ADDR_W-1:0] k0_addr,
  input  logic [DATA_W-1:0] k0_wdata,
  output logic              k0_gnt,
  output logic              k0_rvalid,
  output logic [DATA_W-1:0] k0_rdata,
  input  logic              k1_req,
  input  logic              k1_we,
  input  logic              k1_lock,
  input  logic [ADDR_W-1:0] k1_addr,
  input  logic [DATA_W-1:0] k1_wdata,
  output logic              k1_gnt,
  output logic              k1_rvalid,
  output logic [DATA_W-1:0] k1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tag0_q, tag0_d;
  logic             tag1_q, tag1_d;
  logic             gnt0, gnt1;
  logic             owner_lock;

  // Host cycles and reset cycles freeze the arbiter: no grants, no state movement.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    cnt_inc    = '0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    owner_lock = 1'b0;
    if (!host_sel && !rst) begin
      unique case (state_q)
        IDLE: begin
          if (k0_req && (!k1_req || !rr_q)) gnt0 = 1'b1;
          else if (k1_req)                  gnt1 = 1'b1;
        end
        OWN0:    gnt0 = k0_req;
        OWN1:    gnt1 = k1_req;
        default: ;
      endcase

      if (gnt0 || gnt1) begin
        cnt_inc    = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        owner_lock = gnt0 ? k0_lock : k1_lock;
        if (owner_lock && (cnt_inc < CNT_W'(LOCK_MAX))) begin
          state_d = gnt0 ? OWN0 : OWN1;
          cnt_d   = cnt_inc;
        end else begin
          state_d = IDLE;
          rr_d    = gnt0;
          cnt_d   = '0;
        end
      end else if (state_q != IDLE) begin
        // Owner dropped its request: hand preference to the other kernel.
        state_d = IDLE;
        rr_d    = (state_q == OWN0);
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    tag0_d = gnt0 && !k0_we;
    tag1_d = gnt1 && !k1_we;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_sel) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (gnt0) begin
      mem_we    = k0_we;
      mem_addr  = k0_addr;
      mem_wdata = k0_wdata;
    end else if (gnt1) begin
      mem_we    = k1_we;
      mem_addr  = k1_addr;
      mem_wdata = k1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      tag0_q  <= 1'b0;
      tag1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
    end
  end

  assign k0_gnt     = gnt0;
  assign k1_gnt     = gnt1;
  assign k0_rvalid  = tag0_q && !rst;
  assign k1_rvalid  = tag1_q && !rst;
  assign k0_rdata   = mem_rdata;
  assign k1_rdata   = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_arr_arbiter.sv
// Directed bench for arr_arbiter: round-robin, locking, forced release, host priority and reset.
// A behavioural one-cycle-latency array model sits on the mem_* port.
module tb_arr_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam logic [63:0] D3   = 64'h0123_4567_89AB_0003;
  localparam logic [63:0] D5   = 64'hFEDC_BA98_7654_0005;
  localparam logic [63:0] NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_sel, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              k0_req, k0_we, k0_lock, k0_gnt, k0_rvalid;
  logic [ADDR_W-1:0] k0_addr;
  logic [DATA_W-1:0] k0_wdata, k0_rdata;
  logic              k1_req, k1_we, k1_lock, k1_gnt, k1_rvalid;
  logic [ADDR_W-1:0] k1_addr;
  logic [DATA_W-1:0] k1_wdata, k1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  // Single-port array: write lands at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    mem_rdata <= mem_model[mem_addr];
  end

  arr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .host_sel(host_sel), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .k0_req(k0_req), .k0_we(k0_we), .k0_lock(k0_lock), .k0_addr(k0_addr),
    .k0_wdata(k0_wdata), .k0_gnt(k0_gnt), .k0_rvalid(k0_rvalid), .k0_rdata(k0_rdata),
    .k1_req(k1_req), .k1_we(k1_we), .k1_lock(k1_lock), .k1_addr(k1_addr),
    .k1_wdata(k1_wdata), .k1_gnt(k1_gnt), .k1_rvalid(k1_rvalid), .k1_rdata(k1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  // Drives one cycle of inputs just after the rising edge, then waits to mid-cycle for checks.
  task automatic applyStimulus(input int r, input int hs, input int hwe, input int ha,
                               input logic [63:0] hd,
                               input int q0, input int w0, input int l0, input int a0,
                               input logic [63:0] d0,
                               input int q1, input int w1, input int l1, input int a1,
                               input logic [63:0] d1);
    @(posedge clk);
    #1;
    rst        = (r != 0);
    host_sel   = (hs != 0);
    host_we    = (hwe != 0);
    host_addr  = ADDR_W'(ha);
    host_wdata = hd;
    k0_req     = (q0 != 0);
    k0_we      = (w0 != 0);
    k0_lock    = (l0 != 0);
    k0_addr    = ADDR_W'(a0);
    k0_wdata   = d0;
    k1_req     = (q1 != 0);
    k1_we      = (w1 != 0);
    k1_lock    = (l1 != 0);
    k1_addr    = ADDR_W'(a1);
    k1_wdata   = d1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; host_sel = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    k0_req = 1'b0; k0_we = 1'b0; k0_lock = 1'b0; k0_addr = '0; k0_wdata = '0;
    k1_req = 1'b0; k1_we = 1'b0; k1_lock = 1'b0; k1_addr = '0; k1_wdata = '0;

    // Reset holds off kernel writes, but host passthrough stays live.
    applyStimulus(1, 0,0,0,'0, 1,1,0,1,64'h11, 0,0,0,0,'0);
    checkOutput("rst_gnt0", 64'(k0_gnt), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_rvalid0", 64'(k0_rvalid), 64'd0);
    applyStimulus(1, 1,1,0,64'h99, 1,0,0,1,'0, 1,0,0,2,'0);
    checkOutput("rst_host_we", 64'(mem_we), 64'd1);
    checkOutput("rst_gnt1", 64'(k1_gnt), 64'd0);

    // Preload the array through the host path.
    applyStimulus(0, 1,1,3,D3, 0,0,0,0,'0, 0,0,0,0,'0);
    applyStimulus(0, 1,1,5,D5, 0,0,0,0,'0, 0,0,0,0,'0);
    applyStimulus(0, 1,1,2,NEG3, 1,1,0,9,'0, 1,1,0,9,'0);
    checkOutput("host_pass_addr", 64'(mem_addr), 64'd2);
    checkOutput("host_pass_data", mem_wdata, NEG3);

    // Both kernels read without lock: grants alternate starting with k0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0,0,0,'0, 1,0,0,3,'0, 1,0,0,5,'0);
      checkOutput("rr_gnt0", 64'(k0_gnt), 64'(i % 2 == 0));
      checkOutput("rr_gnt1", 64'(k1_gnt), 64'(i % 2 == 1));
      if (i > 0) begin
        checkOutput("rr_rvalid0", 64'(k0_rvalid), 64'(i % 2 == 1));
        checkOutput("rr_rvalid1", 64'(k1_rvalid), 64'(i % 2 == 0));
        if (i % 2 == 1) checkOutput("rr_rdata0", k0_rdata, D3);
        else            checkOutput("rr_rdata1", k1_rdata, D5);
      end
    end
    applyStimulus(0, 0,0,0,'0, 0,0,0,0,'0, 0,0,0,0,'0);
    checkOutput("rr_last_rvalid1", 64'(k1_rvalid), 64'd1);
    checkOutput("rr_last_rdata1", k1_rdata, D5);
    checkOutput("idle_mem_we", 64'(mem_we), 64'd0);

    // Locked write then read-back by k0 while k1 waits.
    applyStimulus(0, 0,0,0,'0, 1,1,1,7,64'h2A, 1,0,0,5,'0);
    checkOutput("lock_wr_gnt0", 64'(k0_gnt), 64'd1);
    checkOutput("lock_wr_gnt1", 64'(k1_gnt), 64'd0);
    checkOutput("lock_wr_mem_we", 64'(mem_we), 64'd1);
    applyStimulus(0, 0,0,0,'0, 1,0,0,7,'0, 1,0,0,5,'0);
    checkOutput("lock_rd_gnt0", 64'(k0_gnt), 64'd1);
    checkOutput("lock_rd_gnt1", 64'(k1_gnt), 64'd0);
    checkOutput("wr_no_rvalid", 64'(k0_rvalid), 64'd0);
    applyStimulus(0, 0,0,0,'0, 0,0,0,0,'0, 1,0,0,5,'0);
    checkOutput("raw_rvalid0", 64'(k0_rvalid), 64'd1);
    checkOutput("raw_rdata0", k0_rdata, 64'h2A);
    checkOutput("after_lock_gnt1", 64'(k1_gnt), 64'd1);
    applyStimulus(0, 0,0,0,'0, 0,0,0,0,'0, 0,0,0,0,'0);
    checkOutput("after_lock_rdata1", k1_rdata, D5);

    // k0 holds lock forever: 16 grants, forced release to k1, then k0 again.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 0,0,0,'0, 1,0,1,3,'0, 1,0,0,5,'0);
      checkOutput("sat_gnt0", 64'(k0_gnt), 64'(i != 16));
      checkOutput("sat_gnt1", 64'(k1_gnt), 64'(i == 16));
    end
    // k0 drops its request while owning: ownership ends, rr moves to k1.
    applyStimulus(0, 0,0,0,'0, 0,0,0,0,'0, 0,0,0,0,'0);

    // k1 read, then a host write cycle with both kernels requesting.
    applyStimulus(0, 0,0,0,'0, 0,0,0,0,'0, 1,0,0,5,'0);
    checkOutput("hc_pre_gnt1", 64'(k1_gnt), 64'd1);
    applyStimulus(0, 1,1,0,64'h55, 1,0,0,3,'0, 1,0,1,5,'0);
    checkOutput("hc_rvalid1", 64'(k1_rvalid), 64'd1);
    checkOutput("hc_rdata1", k1_rdata, D5);
    checkOutput("hc_gnt0", 64'(k0_gnt), 64'd0);
    checkOutput("hc_gnt1", 64'(k1_gnt), 64'd0);
    checkOutput("hc_mem_wdata", mem_wdata, 64'h55);
    applyStimulus(0, 0,0,0,'0, 1,0,0,3,'0, 1,0,0,5,'0);
    checkOutput("hc_state_gnt0", 64'(k0_gnt), 64'd1);
    checkOutput("hc_no_rvalid1", 64'(k1_rvalid), 64'd0);

    // k1 takes ownership with a read in flight, then reset wipes it.
    applyStimulus(0, 0,0,0,'0, 1,0,0,3,'0, 1,0,1,5,'0);
    checkOutput("own1_gnt1", 64'(k1_gnt), 64'd1);
    checkOutput("own1_rdata0", k0_rdata, D3);
    applyStimulus(1, 0,0,0,'0, 1,0,0,3,'0, 1,0,1,5,'0);
    checkOutput("rst_mid_rvalid1", 64'(k1_rvalid), 64'd0);
    checkOutput("rst_mid_gnt1", 64'(k1_gnt), 64'd0);
    applyStimulus(0, 0,0,0,'0, 1,0,0,3,'0, 1,0,0,5,'0);
    checkOutput("post_rst_rvalid1", 64'(k1_rvalid), 64'd0);
    checkOutput("post_rst_gnt0", 64'(k0_gnt), 64'd1);
    checkOutput("post_rst_gnt1", 64'(k1_gnt), 64'd0);

    // Host reads the negative value; kernels are locked out that cycle.
    applyStimulus(0, 1,0,2,'0, 1,0,0,3,'0, 1,0,0,5,'0);
    checkOutput("hr_gnt0", 64'(k0_gnt), 64'd0);
    checkOutput("hr_gnt1", 64'(k1_gnt), 64'd0);
    checkOutput("hr_mem_we", 64'(mem_we), 64'd0);
    applyStimulus(0, 0,0,0,'0, 0,0,0,0,'0, 0,0,0,0,'0);
    checkOutput("hr_rdata", host_rdata, NEG3);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
